// File: rtl/paint_canvas_clear.sv
// Canvas clear sequencer: sweeps addresses 0..LAST_ADDR writing one colour over a valid/ready port.
// Optional runtime colour input enabled with `define CLEAR_COLOR_EN; otherwise WHITE is written.
module paint_canvas_clear #(
    parameter int                 ADDR_W    = 12,
    parameter int                 DATA_W    = 24,
    parameter int                 LAST_ADDR = 4095,
    parameter logic [DATA_W-1:0]  WHITE     = {DATA_W{1'b1}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              init,
    input  logic              abort,
    input  logic              wr_ready,
`ifdef CLEAR_COLOR_EN
    input  logic [DATA_W-1:0] clear_color,
`endif
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_A = LAST_ADDR[ADDR_W-1:0];
    localparam logic [ADDR_W-1:0] ONE_A  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] ZERO_A = {ADDR_W{1'b0}};
    localparam logic [DATA_W-1:0] ZERO_D = {DATA_W{1'b0}};

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   addr_r,  addr_s;
    logic [DATA_W-1:0]   data_r,  data_s;
    logic                wr_en_r, wr_en_s;
    logic                busy_r,  busy_s;
    logic                done_r,  done_s;
    logic [DATA_W-1:0]   color_src_s;

`ifdef CLEAR_COLOR_EN
    assign color_src_s = clear_color;
`else
    assign color_src_s = WHITE;
`endif

    // Next-state and next-output logic; every output is computed here and registered below.
    always_comb begin
        state_s = state_r;
        addr_s  = addr_r;
        data_s  = data_r;
        wr_en_s = wr_en_r;
        busy_s  = busy_r;
        done_s  = done_r;
        case (state_r)
            ST_IDLE: begin
                if (init) begin
                    state_s = ST_WRITE;
                    addr_s  = ZERO_A;
                    data_s  = color_src_s;
                    wr_en_s = 1'b1;
                    busy_s  = 1'b1;
                    done_s  = 1'b0;
                end else begin
                    state_s = ST_IDLE;
                    addr_s  = ZERO_A;
                    data_s  = ZERO_D;
                    wr_en_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end
            end
            ST_WRITE: begin
                // Abort wins over acceptance: a write taken on the abort edge is not counted.
                if (abort) begin
                    state_s = ST_IDLE;
                    addr_s  = ZERO_A;
                    data_s  = ZERO_D;
                    wr_en_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end else if (wr_ready) begin
                    if (addr_r == LAST_A) begin
                        state_s = ST_DONE;
                        wr_en_s = 1'b0;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        state_s = ST_WRITE;
                        addr_s  = addr_r + ONE_A;
                    end
                end else begin
                    state_s = ST_WRITE;
                    addr_s  = addr_r;
                    data_s  = data_r;
                end
            end
            ST_DONE: begin
                if (init) begin
                    state_s = ST_DONE;
                    wr_en_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                    addr_s  = ZERO_A;
                    data_s  = ZERO_D;
                    wr_en_s = 1'b0;
                    busy_s  = 1'b0;
                    done_s  = 1'b0;
                end
            end
            default: begin
                state_s = ST_IDLE;
                addr_s  = ZERO_A;
                data_s  = ZERO_D;
                wr_en_s = 1'b0;
                busy_s  = 1'b0;
                done_s  = 1'b0;
            end
        endcase
    end

    // State and output registers, updated on the falling edge with synchronous reset.
    always_ff @(negedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            addr_r  <= ZERO_A;
            data_r  <= ZERO_D;
            wr_en_r <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            addr_r  <= addr_s;
            data_r  <= data_s;
            wr_en_r <= wr_en_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    assign wr_en   = wr_en_r;
    assign wr_addr = addr_r;
    assign wr_data = data_r;
    assign busy    = busy_r;
    assign done    = done_r;

endmodule

// File: tb/tb_paint_canvas_clear.sv
// Directed bench for paint_canvas_clear with LAST_ADDR=7; DUT acts on negedge, bench drives/samples on posedge.
module tb_paint_canvas_clear;

    localparam int ADDR_W = 12;
    localparam int DATA_W = 24;
    localparam logic [DATA_W-1:0] CLR0 = 24'h0000FF;
    localparam logic [DATA_W-1:0] CLR1 = 24'hFF0000;
`ifdef CLEAR_COLOR_EN
    localparam logic [DATA_W-1:0] EXP_COLOR = 24'h0000FF;
`else
    localparam logic [DATA_W-1:0] EXP_COLOR = 24'hFFFFFF;
`endif

    logic              clk = 1'b1;
    logic              rst;
    logic              init;
    logic              abort;
    logic              wr_ready;
    logic [DATA_W-1:0] clear_color;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;

    paint_canvas_clear #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LAST_ADDR(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .init       (init),
        .abort      (abort),
        .wr_ready   (wr_ready),
`ifdef CLEAR_COLOR_EN
        .clear_color(clear_color),
`endif
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(posedge clk);
    endtask

    // One sweep from IDLE; stall alternates wr_ready starting low, hold_init keeps init high throughout.
    task automatic sweep(input bit stall, input bit hold_init);
        int nw, nb, last_w, done_at;
        bit rdy;
        nw = 0; nb = 0; last_w = -1; done_at = -1;
        clear_color = CLR0;
        wr_ready = 1'b1;
        init = 1'b1;
        @(posedge clk);
        if (!hold_init) init = 1'b0;
        for (int c = 0; c < 40; c++) begin
            check("busy_done_excl", {31'd0, busy & done}, 32'd0);
            if (busy) nb++;
            if (wr_en) begin
                check("sweep_addr", {20'd0, wr_addr}, nw);
                check("sweep_data", {8'd0, wr_data}, {8'd0, EXP_COLOR});
                rdy = stall ? (c % 2 == 1) : 1'b1;
                wr_ready = rdy;
                if (rdy) begin
                    nw++;
                    last_w = c;
                end
            end
            if (done) begin
                done_at = c;
                break;
            end
            if (c == 3) clear_color = CLR1;
            @(posedge clk);
        end
        wr_ready = 1'b1;
        check("sweep_nwrites", nw, 32'd8);
        check("sweep_done_at", done_at, last_w + 1);
        check("sweep_busy_cycles", nb, stall ? 32'd16 : 32'd8);
        check("sweep_done", {31'd0, done}, 32'd1);
        check("sweep_busy_end", {31'd0, busy}, 32'd0);
    endtask

    // Run a sweep until wr_addr==at, then apply abort or reset on that edge (with wr_ready high).
    task automatic interrupt_at(input int at, input bit use_rst);
        bit hit;
        hit = 1'b0;
        wr_ready = 1'b1;
        init = 1'b1;
        @(posedge clk);
        init = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (wr_en && wr_addr == at[ADDR_W-1:0]) begin
                if (use_rst) rst = 1'b1; else abort = 1'b1;
                @(posedge clk);
                rst = 1'b0;
                abort = 1'b0;
                hit = 1'b1;
                break;
            end
            @(posedge clk);
        end
        check("intr_reached", {31'd0, hit}, 32'd1);
        check("intr_wr_en", {31'd0, wr_en}, 32'd0);
        check("intr_busy", {31'd0, busy}, 32'd0);
        check("intr_done", {31'd0, done}, 32'd0);
        check("intr_addr", {20'd0, wr_addr}, 32'd0);
        check("intr_data", {8'd0, wr_data}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; init = 1'b0; abort = 1'b0; wr_ready = 1'b1; clear_color = CLR0;
        @(posedge clk);
        check("rst_wr_en", {31'd0, wr_en}, 32'd0);
        check("rst_addr", {20'd0, wr_addr}, 32'd0);
        check("rst_data", {8'd0, wr_data}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        rst = 1'b0;
        init = 1'b1;
        check("rst_still_idle", {31'd0, wr_en}, 32'd0);
        init = 1'b0;
        idle_cycles(2);

        // Full sweep, no stalls; then back to IDLE once init is low.
        sweep(1'b0, 1'b0);
        @(posedge clk);
        check("done_to_idle", {31'd0, done}, 32'd0);

        // Back-pressure on every other cycle.
        sweep(1'b1, 1'b0);
        idle_cycles(2);

        // Abort at address 3, stays idle, then restart from 0.
        interrupt_at(3, 1'b0);
        idle_cycles(3);
        check("abort_idle_done", {31'd0, done}, 32'd0);
        check("abort_idle_wr_en", {31'd0, wr_en}, 32'd0);
        sweep(1'b0, 1'b0);
        idle_cycles(2);

        // Reset at address 5: no writes afterwards without init.
        interrupt_at(5, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            check("post_rst_no_write", {31'd0, wr_en}, 32'd0);
        end
        sweep(1'b0, 1'b0);
        idle_cycles(2);

        // Abort together with wr_ready on the last address.
        interrupt_at(7, 1'b0);
        @(posedge clk);
        check("abort_last_done", {31'd0, done}, 32'd0);

        // Holding init in DONE does not restart; fall then rise does.
        sweep(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            check("hold_done", {31'd0, done}, 32'd1);
            check("hold_no_write", {31'd0, wr_en}, 32'd0);
        end
        init = 1'b0;
        @(posedge clk);
        check("drop_init_done", {31'd0, done}, 32'd0);
        check("drop_init_busy", {31'd0, busy}, 32'd0);
        init = 1'b1;
        @(posedge clk);
        init = 1'b0;
        check("restart_wr_en", {31'd0, wr_en}, 32'd1);
        check("restart_addr", {20'd0, wr_addr}, 32'd0);
        abort = 1'b1;
        @(posedge clk);
        abort = 1'b0;
        check("restart_abort", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/paint_canvas_clear.md
# paint_canvas_clear

Framebuffer write sequencer for retro_paint. On `init` it sweeps every canvas address from 0 to `LAST_ADDR` and writes the clear colour (white by default) into canvas memory over a valid/ready write port, then holds `done`. It is the writer side of the canvas-blanking path: the paint FSM starts it, and the canvas RAM or arbiter accepts its writes.

## Interface
- `ADDR_W`, 12: canvas address width (64x64 pixels).
- `DATA_W`, 24: pixel width, RGB888.
- `LAST_ADDR`, 4095: final address written; must fit in `ADDR_W` bits.
- `WHITE`, 24'hFFFFFF: fixed clear colour.
- `clk`  in  1  clock; all state updates on the falling edge.
- `rst`  in  1  reset, synchronous, active-high.
- `init`  in  1  start request, level-sensitive.
- `abort`  in  1  cancel an in-progress sweep.
- `wr_ready`  in  1  memory/arbiter accepts the current write.
- `clear_color`  in  DATA_W  runtime colour; present only with `CLEAR_COLOR_EN`.
- `wr_en`  out  1  write valid.
- `wr_addr`  out  ADDR_W  write address.
- `wr_data`  out  DATA_W  write data.
- `busy`  out  1  sweep in progress.
- `done`  out  1  sweep completed.

## Operation
- All outputs are registered. The state machine has three states: IDLE, WRITE, DONE.
- **IDLE**: `wr_en`=0, `busy`=0, `done`=0, internal address=0.
  - `init`=1 → WRITE with address 0.
  - The colour is latched into `wr_data` on entry to WRITE.
- **WRITE**: `wr_en`=1, `busy`=1, `wr_addr`=current address, `wr_data`=latched colour.
  - A write is accepted on any edge where `wr_en`=1 and `wr_ready`=1.
  - Accepted, address < `LAST_ADDR` → address+1, stay in WRITE.
  - Accepted, address == `LAST_ADDR` → DONE.
  - `wr_ready`=0 → hold address, data and `wr_en` unchanged. There is no timeout.
  - `abort`=1 → IDLE, address=0, `done` never asserted. Abort has priority over acceptance, including on the last address.
  - If `abort` and `wr_ready` are both high on the same edge, that write is still taken by memory but not counted here.
- **DONE**: `wr_en`=0, `busy`=0, `done`=1.
  - Stays in DONE while `init`=1.
  - `init`=0 → IDLE.
  - A new sweep therefore requires `init` to fall and then rise again.
  - `abort` is ignored in DONE.
- `init` is ignored outside IDLE. `abort` is ignored in IDLE.
- Address arithmetic is unsigned `ADDR_W`. The address never wraps, because the increment stops at `LAST_ADDR`.
- `wr_addr` and `wr_data` are don't-care while `wr_en`=0, but are driven to 0 in IDLE.
- The colour is sampled once per sweep. Changing it mid-sweep has no effect.

## Timing
- Reset: on the first falling edge with `rst`=1, the block enters IDLE and sets `wr_en`=0, `wr_addr`=0, `wr_data`=0, `busy`=0, `done`=0.
  - Reset overrides every other input, including mid-sweep. No further writes are issued after that edge.
- Start latency: `init` sampled high at edge N → `wr_en`=1 with `wr_addr`=0 after edge N.
- Throughput: one write per cycle while `wr_ready` stays high. A full sweep with no stalls takes `LAST_ADDR`+1 write cycles.
- `done` rises on the edge that accepts address `LAST_ADDR`.
- `busy` and `done` are never high together.

## Configuration
- `CLEAR_COLOR_EN` defined:
  - The `clear_color` port exists.
  - Its value is latched on the IDLE→WRITE edge and used for the whole sweep.
- `CLEAR_COLOR_EN` undefined:
  - The port is absent.
  - `WHITE` is latched instead.
  - Behaviour is otherwise identical.

## Test plan
- Full sweep, `LAST_ADDR`=7, `wr_ready` tied high, `init` pulsed high:
  - Exactly 8 writes to addresses 0..7 with `wr_data`=24'hFFFFFF.
  - `done`=1 from the edge after the 8th write.
  - `busy` is high for exactly 8 cycles.
- Back-pressure, `LAST_ADDR`=7, `wr_ready` low on every other cycle:
  - Addresses 0..7 each accepted once, with no skips or repeats.
  - Address and data are held stable while stalled.
- Abort at address 3:
  - `wr_en` drops on the next edge, IDLE is entered and `done` stays 0.
  - Re-init restarts from address 0.
- Reset at address 5:
  - All outputs are 0 after the reset edge.
  - No writes follow until `init` is asserted again.
- Simultaneous `abort` and `wr_ready` at address 7:
  - Ends in IDLE with `done`=0.
- `CLEAR_COLOR_EN` defined, `clear_color`=24'h0000FF at start and changed to 24'hFF0000 mid-sweep:
  - All 8 writes carry 24'h0000FF.
  - Holding `init` high in DONE does not restart; dropping then raising `init` starts a new sweep.
